move_input_ctrl: RTL and testbench



---
 rtl/move_input_pkg.sv | 50 +++++
 rtl/move_input_ctrl_debounce.sv | 51 +++++
 rtl/move_input_ctrl.sv | 78 +++++++
 tb/tb_move_input_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/move_input_pkg.sv
// Shared types and constants for the push-button movement front end.
// Axis FSM state encoding, button bit indices, and the axis transition function.
package move_input_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NEG  = 2'd1,
      POS  = 2'd2
   } axis_state_t;

   localparam int BTN_UP    = 3;
   localparam int BTN_DOWN  = 2;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_RIGHT = 0;

   // Last-pressed-wins resolution of two opposing debounced levels.
   function automatic axis_state_t axis_next(
      input axis_state_t cur,
      input logic        neg,
      input logic        pos,
      input logic        neg_rise,
      input logic        pos_rise
   );
      axis_state_t nxt;
      nxt = cur;
      unique case (cur)
         IDLE: begin
            if (neg && !pos)
               nxt = NEG;
            else if (pos && !neg)
               nxt = POS;
         end
         NEG: begin
            if (!neg)
               nxt = pos ? POS : IDLE;
            else if (pos_rise)
               nxt = POS;
         end
         POS: begin
            if (!pos)
               nxt = neg ? NEG : IDLE;
            else if (neg_rise)
               nxt = NEG;
         end
         default: nxt = IDLE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/move_input_ctrl_debounce.sv
// One button: two-flop synchroniser, counter debounce, registered rise pulse.
// level/rise feed the axis FSMs; pulse is the registered press strobe.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic pad,
   output logic level,
   output logic rise,
   output logic pulse
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             s;
   logic             stable;
   logic             stable_d;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= 1'b0;
         s        <= 1'b0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         cnt      <= '0;
         pulse    <= 1'b0;
      end else begin
         sync1    <= pad;
         s        <= sync1;
         stable_d <= stable;
         pulse    <= rise;
         // Any agreeing cycle restarts the count, so bounces never accumulate.
         if (s == stable) begin
            cnt <= '0;
         end else if (cnt == TERM) begin
            stable <= s;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign level = stable;
   assign rise  = stable & ~stable_d;

endmodule

// File: rtl/move_input_ctrl.sv
// Debounced up/down/left/right levels plus press pulses from four raw pads.
// Define MOVE_INPUT_DIAGONAL_EN to let both axes drive outputs together.
module move_input_ctrl
   import move_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic       CLK100MHZ,
   input  logic       rst,
   input  logic [3:0] btn_raw,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic [3:0] press_pulse
);

   logic [3:0]  level;
   logic [3:0]  rise;
   axis_state_t v_q;
   axis_state_t v_d;
   axis_state_t h_q;
   axis_state_t h_d;
   logic [3:0]  dir_q;
   logic [3:0]  dir_d;

   for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_db (
         .clk   (CLK100MHZ),
         .rst   (rst),
         .pad   (btn_raw[i]),
         .level (level[i]),
         .rise  (rise[i]),
         .pulse (press_pulse[i])
      );
   end

   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         v_q   <= IDLE;
         h_q   <= IDLE;
         dir_q <= '0;
      end else begin
         v_q   <= v_d;
         h_q   <= h_d;
         dir_q <= dir_d;
      end
   end

   always_comb begin
      v_d   = axis_next(v_q, level[BTN_UP], level[BTN_DOWN],
                        rise[BTN_UP], rise[BTN_DOWN]);
      h_d   = axis_next(h_q, level[BTN_LEFT], level[BTN_RIGHT],
                        rise[BTN_LEFT], rise[BTN_RIGHT]);
      dir_d = '0;
      dir_d[BTN_UP]    = (v_d == NEG);
      dir_d[BTN_DOWN]  = (v_d == POS);
      dir_d[BTN_LEFT]  = (h_d == NEG);
      dir_d[BTN_RIGHT] = (h_d == POS);
`ifndef MOVE_INPUT_DIAGONAL_EN
      // Horizontal stays masked until vertical has been idle a full cycle.
      if (v_q != IDLE || v_d != IDLE) begin
         dir_d[BTN_LEFT]  = 1'b0;
         dir_d[BTN_RIGHT] = 1'b0;
      end
`endif
   end

   assign up    = dir_q[BTN_UP];
   assign down  = dir_q[BTN_DOWN];
   assign left  = dir_q[BTN_LEFT];
   assign right = dir_q[BTN_RIGHT];

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl with DEBOUNCE_CYCLES=4 (7-cycle latency).
// Table of {pads, wait, expected dirs, expected pulses} plus reset sequences.
module tb_move_input_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_raw;
   logic       up;
   logic       down;
   logic       left;
   logic       right;
   logic [3:0] press_pulse;
   logic [3:0] dirs;
   logic       mon_en = 1'b0;

   int total = 0;
   int bad   = 0;

`ifdef MOVE_INPUT_DIAGONAL_EN
   localparam bit DIAG = 1'b1;
`else
   localparam bit DIAG = 1'b0;
`endif

   typedef struct {
      logic [3:0] btn;
      int         n;
      logic [3:0] dirs;
      logic [3:0] pulse;
   } vec_t;

   vec_t tbl[$];

   move_input_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .CLK100MHZ   (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .up          (up),
      .down        (down),
      .left        (left),
      .right       (right),
      .press_pulse (press_pulse)
   );

   always #5 clk = ~clk;

   assign dirs = {up, down, left, right};

   function automatic void add(logic [3:0] b, int n,
                               logic [3:0] d, logic [3:0] p);
      vec_t v;
      v.btn   = b;
      v.n     = n;
      v.dirs  = d;
      v.pulse = p;
      tbl.push_back(v);
   endfunction

   task automatic check(string name, logic [3:0] got, logic [3:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b want=%b", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         total++;
         if ((up && down) || (left && right)
`ifndef MOVE_INPUT_DIAGONAL_EN
             || ((up || down) && (left || right))
`endif
            ) begin
            bad++;
            $display("FAIL invariant dirs=%b", dirs);
         end
      end
   end

   initial begin
      // clean press / release of up
      add(4'b1000, 6, 4'b0000, 4'b0000);
      add(4'b1000, 1, 4'b1000, 4'b1000);
      add(4'b1000, 1, 4'b1000, 4'b0000);
      add(4'b0000, 6, 4'b1000, 4'b0000);
      add(4'b0000, 1, 4'b0000, 4'b0000);
      // left bounces then settles
      add(4'b0010, 1, 4'b0000, 4'b0000);
      add(4'b0000, 1, 4'b0000, 4'b0000);
      add(4'b0010, 1, 4'b0000, 4'b0000);
      add(4'b0000, 1, 4'b0000, 4'b0000);
      add(4'b0010, 6, 4'b0000, 4'b0000);
      add(4'b0010, 1, 4'b0010, 4'b0010);
      add(4'b0000, 7, 4'b0000, 4'b0000);
      // last pressed wins on vertical
      add(4'b1000, 7, 4'b1000, 4'b1000);
      add(4'b1100, 6, 4'b1000, 4'b0000);
      add(4'b1100, 1, 4'b0100, 4'b0100);
      add(4'b1000, 6, 4'b0100, 4'b0000);
      add(4'b1000, 1, 4'b1000, 4'b0000);
      add(4'b0000, 7, 4'b0000, 4'b0000);
      // simultaneous left+right
      add(4'b0011, 7, 4'b0000, 4'b0011);
      add(4'b0011, 1, 4'b0000, 4'b0000);
      add(4'b0010, 6, 4'b0000, 4'b0000);
      add(4'b0010, 1, 4'b0010, 4'b0000);
      add(4'b0000, 7, 4'b0000, 4'b0000);
      // up + right: diagonal or vertical priority
      add(4'b1001, 7, DIAG ? 4'b1001 : 4'b1000, 4'b1001);
      add(4'b0001, 6, DIAG ? 4'b1001 : 4'b1000, 4'b0000);
      add(4'b0001, 1, DIAG ? 4'b0001 : 4'b0000, 4'b0000);
      add(4'b0001, 1, 4'b0001, 4'b0000);
      add(4'b0000, 7, 4'b0000, 4'b0000);

      rst     = 1'b1;
      btn_raw = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      check("reset dirs", dirs, 4'b0000);
      check("reset pulse", press_pulse, 4'b0000);
      rst    = 1'b0;
      mon_en = 1'b1;

      foreach (tbl[i]) begin
         btn_raw = tbl[i].btn;
         repeat (tbl[i].n) @(posedge clk);
         #1;
         check($sformatf("vec%0d dirs", i), dirs, tbl[i].dirs);
         check($sformatf("vec%0d pulse", i), press_pulse, tbl[i].pulse);
      end

      // reset at debounce count 2 while down is held
      btn_raw = 4'b0100;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_mid dirs", dirs, 4'b0000);
      check("rst_mid pulse", press_pulse, 4'b0000);
      repeat (6) @(posedge clk);
      #1;
      check("rst_resync early", dirs, 4'b0000);
      @(posedge clk);
      #1;
      check("rst_resync dirs", dirs, 4'b0100);
      check("rst_resync pulse", press_pulse, 4'b0100);

      // reset while down is active clears it, then it re-acquires
      repeat (2) @(posedge clk);
      #1;
      check("down held", dirs, 4'b0100);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_active dirs", dirs, 4'b0000);
      repeat (6) @(posedge clk);
      #1;
      check("rst_active early", dirs, 4'b0000);
      @(posedge clk);
      #1;
      check("rst_active again", dirs, 4'b0100);

      btn_raw = 4'b0000;
      repeat (7) @(posedge clk);
      #1;
      check("final release", dirs, 4'b0000);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
